ca2_sched: RTL and testbench

- Shares a single two's-complement negation unit (R = -A, CCR = CVNZ) between N_REQ requesters.
- Round-robin arbitration, per-requester valid/ready on the input side, one valid/ready response channel tagged with the requester index.
- Results and flags are registered, so downstream logic sees stable R/CCR instead of flags that settle over several delays.
- Sits between the register-file read ports and the CCR/writeback stage.

---
 rtl/ca2_pkg.sv | 30 +++
 rtl/ca2_sched_if.sv | 26 ++
 rtl/ca2_core.sv | 22 ++
 rtl/ca2_sched.sv | 94 +++++++++
 tb/tb_ca2_sched.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ca2_pkg.sv
// rtl/ca2_pkg.sv - shared CCR layout, FSM states and round-robin helper for ca2_sched
package ca2_pkg;

    localparam int CCR_C = 3;
    localparam int CCR_V = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    localparam logic [3:0] C_MASK = 4'b1000;
    localparam logic [3:0] V_MASK = 4'b0100;
    localparam logic [3:0] N_MASK = 4'b0010;
    localparam logic [3:0] Z_MASK = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    // First set bit scanning last+1, last+2, ... modulo n; -1 when nothing is valid.
    function automatic int rr_pick(input logic [15:0] valid, input int last, input int n);
        rr_pick = -1;
        for (int k = 1; k <= n; k++) begin
            if (rr_pick < 0 && valid[(last + k) % n]) begin
                rr_pick = (last + k) % n;
            end
        end
    endfunction

endpackage

// File: rtl/ca2_sched_if.sv
// rtl/ca2_sched_if.sv - requester and response channels of the shared negation unit
interface ca2_sched_if #(
    parameter int OP_SIZE = 4,
    parameter int N_REQ   = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*OP_SIZE-1:0] req_a;
    logic [N_REQ-1:0]         req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [OP_SIZE-1:0]       rsp_r;
    logic [3:0]               rsp_ccr;

    modport master (
        output req_valid, req_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_r, rsp_ccr
    );

    modport slave (
        input  req_valid, req_a, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_r, rsp_ccr
    );
endinterface

// File: rtl/ca2_core.sv
// rtl/ca2_core.sv - combinational two's-complement negation with CVNZ flags
module ca2_core
    import ca2_pkg::*;
#(
    parameter int OP_SIZE = 4
) (
    input  logic [OP_SIZE-1:0] a,
    output logic [OP_SIZE-1:0] r,
    output logic [3:0]         ccr
);

    always_comb begin
        r   = '0 - a;
        ccr = '0;
        if (a != '0)             ccr = ccr | C_MASK;
        // Only the most negative value negates onto itself.
        if (a != '0 && a == r)   ccr = ccr | V_MASK;
        if (r[OP_SIZE-1])        ccr = ccr | N_MASK;
        if (r == '0)             ccr = ccr | Z_MASK;
    end

endmodule

// File: rtl/ca2_sched.sv
// rtl/ca2_sched.sv - round-robin scheduler sharing one ca2_core between N_REQ requesters
module ca2_sched
    import ca2_pkg::*;
#(
    parameter int OP_SIZE = 4,
    parameter int N_REQ   = 4,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic        clk,
    input  logic        rst,
    ca2_sched_if.slave  bus
);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    grant;
    int                 pick;
    logic [OP_SIZE-1:0] op_a;
    logic [ID_W-1:0]    op_id;
    logic [OP_SIZE-1:0] core_r;
    logic [3:0]         core_ccr;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [OP_SIZE-1:0] rsp_r;
    logic [3:0]         rsp_ccr;

    ca2_core #(.OP_SIZE(OP_SIZE)) u_core (
        .a   (op_a),
        .r   (core_r),
        .ccr (core_ccr)
    );

    always_comb begin
        pick  = rr_pick(16'(bus.req_valid), int'(last), N_REQ);
        grant = ID_W'(pick);
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (pick >= 0) begin
                    bus.req_ready[grant] = 1'b1;
                    state_nxt            = CALC;
                end
            end
            CALC:    state_nxt = HOLD;
            HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A grant seen during reset would be a handshake the FSM never honours.
        if (rst) bus.req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ID_W'(N_REQ - 1);
            op_a      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_r     <= '0;
            rsp_ccr   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick >= 0) begin
                        op_a  <= bus.req_a[grant*OP_SIZE +: OP_SIZE];
                        op_id <= grant;
                        last  <= grant;
                    end
                end
                CALC: begin
                    rsp_r     <= core_r;
                    rsp_ccr   <= core_ccr;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end
                HOLD:    if (bus.rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_r     = rsp_r;
    assign bus.rsp_ccr   = rsp_ccr;

endmodule

// File: tb/tb_ca2_sched.sv
// tb/tb_ca2_sched.sv - vector table and scoreboard bench for ca2_sched
module tb_ca2_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ca2_sched_if #(.OP_SIZE(4), .N_REQ(4)) bus ();

    ca2_sched #(.OP_SIZE(4), .N_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vmask;
        logic [15:0] ap;
        int          g;
        logic [3:0]  r;
        logic [3:0]  ccr;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] r;
        logic [3:0] ccr;
    } exp_t;

    vec_t vecs[11];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_neg(input int a);
        logic [3:0] rv;
        logic [3:0] cc;
        rv = 4'((16 - a) % 16);
        cc = {a != 0, a == 8, rv >= 4'd8, rv == 4'd0};
        return {rv, cc};
    endfunction

    // Entered at a negedge with the DUT in IDLE; leaves at a negedge back in IDLE.
    task automatic issue(input string tag, input logic [3:0] vmask, input logic [15:0] ap,
                         input int eg, input logic [3:0] er, input logic [3:0] eccr);
        exp_t e;
        bus.req_valid = vmask;
        bus.req_a     = ap;
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_grant"}, bus.req_ready, 32'(4'b0001 << eg));
        sbq.push_back('{eg, er, eccr});
        @(negedge clk);
        chk({tag, "_calc_ready"}, bus.req_ready, 0);
        chk({tag, "_calc_valid"}, bus.rsp_valid, 0);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                chk({tag, "_sb_empty"}, 1, 0);
            end else begin
                e = sbq.pop_front();
                chk({tag, "_id"},  bus.rsp_id,  e.id);
                chk({tag, "_r"},   bus.rsp_r,   e.r);
                chk({tag, "_ccr"}, bus.rsp_ccr, e.ccr);
            end
        end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rc;

        vecs[0]  = '{4'b1111, 16'h7A53, 0, 4'hD, 4'b1010};
        vecs[1]  = '{4'b1111, 16'h7A53, 1, 4'hB, 4'b1010};
        vecs[2]  = '{4'b1111, 16'h7A53, 2, 4'h6, 4'b1000};
        vecs[3]  = '{4'b1111, 16'h7A53, 3, 4'h9, 4'b1010};
        vecs[4]  = '{4'b1111, 16'h7A53, 0, 4'hD, 4'b1010};
        vecs[5]  = '{4'b0001, 16'h0003, 0, 4'hD, 4'b1010};
        vecs[6]  = '{4'b0100, 16'h0000, 2, 4'h0, 4'b0001};
        vecs[7]  = '{4'b0100, 16'h0800, 2, 4'h8, 4'b1110};
        vecs[8]  = '{4'b0100, 16'h0F00, 2, 4'h1, 4'b1000};
        vecs[9]  = '{4'b1010, 16'h1030, 3, 4'hF, 4'b1010};
        vecs[10] = '{4'b1010, 16'h1030, 1, 4'hD, 4'b1010};

        bus.req_valid = 4'b1111;
        bus.req_a     = 16'h7A53;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_valid", bus.rsp_valid, 0);
            chk("rst_id",    bus.rsp_id,    0);
            chk("rst_r",     bus.rsp_r,     0);
            chk("rst_ccr",   bus.rsp_ccr,   0);
        end
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].vmask, vecs[i].ap, vecs[i].g, vecs[i].r, vecs[i].ccr);
        end

        // Backpressure: last=1, so requester 2 wins; A2=1010 gives R=0110, CCR=1000.
        bus.req_valid = 4'b1111;
        bus.req_a     = 16'h7A53;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_grant", bus.req_ready, 32'b0100);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_id",    bus.rsp_id,    2);
            chk("bp_r",     bus.rsp_r,     4'h6);
            chk("bp_ccr",   bus.rsp_ccr,   4'b1000);
            chk("bp_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus.rsp_valid, 0);

        // Reset during CALC: no response, pointer back to N_REQ-1.
        bus.req_valid = 4'b0001;
        bus.req_a     = 16'h0003;
        #1;
        chk("mid_grant", bus.req_ready, 32'b0001);
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after_valid", bus.rsp_valid, 0);
        issue("mid_regrant", 4'b1010, 16'h1030, 1, 4'hD, 4'b1010);

        for (int a = 0; a < 16; a++) begin
            rc = ref_neg(a);
            issue($sformatf("sweep%0d", a), 4'b0010, 16'(a << 4), 1, rc[7:4], rc[3:0]);
        end

        chk("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
